// File: rtl/line_read_buffer_if.sv
// line_read_buffer_if
// Refill request/response and AXI read-beat signals for the line read buffer.
//   slave  modport : the line_read_buffer itself
//   master modport : refill controller plus AXI read master (drives requests and beats)
// Signals:
//   Enable, Address                 refill request (level) and miss byte address
//   AXIRData, AXIRValid, AXIRLast   incoming read beats
//   AXIAddr, AXIStartRead           read command toward the AXI master
//   LR_Data, LR_Completed, LR_Error assembled line and status
//   CritWord, CritValid             critical word strobe (CRITICAL_WORD_FIRST_EN builds)
interface line_read_buffer_if #(
    parameter int LINE_W = 256
);
    logic              Enable;
    logic [31:0]       Address;
    logic [31:0]       AXIRData;
    logic              AXIRValid;
    logic              AXIRLast;
    logic [31:0]       AXIAddr;
    logic              AXIStartRead;
    logic [LINE_W-1:0] LR_Data;
    logic              LR_Completed;
    logic              LR_Error;
    logic [31:0]       CritWord;
    logic              CritValid;

    modport slave (
        input  Enable, Address, AXIRData, AXIRValid, AXIRLast,
        output AXIAddr, AXIStartRead, LR_Data, LR_Completed, LR_Error, CritWord, CritValid
    );

    modport master (
        output Enable, Address, AXIRData, AXIRValid, AXIRLast,
        input  AXIAddr, AXIStartRead, LR_Data, LR_Completed, LR_Error, CritWord, CritValid
    );
endinterface

// File: rtl/line_read_buffer.sv
// line_read_buffer
// Fetches one 256-bit cache line from the AXI read master on a miss: one start
// pulse with the line address, eight 32-bit beats assembled into LR_Data, then
// LR_Completed held until the refill request (Enable) drops.
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset (shared with the AXI read master)
//   bus    line_read_buffer_if.slave (request, beats, line/status outputs)
// Optional build macro CRITICAL_WORD_FIRST_EN: word-aligned request address,
// beats wrap from the requested word, and the first beat is echoed on CritWord.
module line_read_buffer #(
    parameter int BEATS  = 8,
    parameter int LINE_W = 256
) (
    input  logic              Clk,
    input  logic              Rst_n,
    line_read_buffer_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_COLLECT, S_DONE, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_armed;
    logic [2:0]        r_cnt;
    logic [31:0]       r_addr;
    logic              r_start;
    logic [LINE_W-1:0] r_data;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_crit;
    logic              r_critv;

    logic              w_accept;
    logic              w_write;
    logic              w_consume;
    logic              w_final;
    logic              w_err;
    logic              w_last_slot;
    logic [2:0]        w_idx;
    logic              w_unused_addr;

    // Low address bits are only meaningful in some build variants.
    assign w_unused_addr = ^bus.Address[4:0];

`ifdef CRITICAL_WORD_FIRST_EN
    logic [2:0] r_start_idx;
    assign w_idx = r_start_idx + r_cnt;
`else
    assign w_idx = r_cnt;
`endif

    // The 8th beat ends the transfer even without RLast; RLast on any other
    // beat ends it early. Either disagreement is an error.
    assign w_last_slot = (r_cnt == 3'(BEATS - 1));
    assign w_final     = bus.AXIRValid && (bus.AXIRLast || w_last_slot);
    assign w_err       = bus.AXIRLast != w_last_slot;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_write      = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Enable && r_armed) begin
                    w_accept     = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // The start pulse completes regardless; a drop here aborts.
                w_state_next = bus.Enable ? S_COLLECT : S_DRAIN;
            end
            S_COLLECT: begin
                if (!bus.Enable) begin
                    // Abort: a beat arriving now is counted but not stored.
                    w_consume    = bus.AXIRValid;
                    w_state_next = w_final ? S_IDLE : S_DRAIN;
                end else if (bus.AXIRValid) begin
                    w_write   = 1'b1;
                    w_consume = 1'b1;
                    if (w_final) w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.Enable) w_state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.AXIRValid) begin
                    w_consume = 1'b1;
                    if (w_final) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_armed <= 1'b1;
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_crit  <= 32'd0;
            r_critv <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_start_idx <= 3'd0;
`endif
        end else begin
            r_start <= w_accept;
            // Re-arm on any sampled low Enable: one transfer per assertion.
            if (!bus.Enable)  r_armed <= 1'b1;
            else if (w_accept) r_armed <= 1'b0;

            if (w_accept) begin
`ifdef CRITICAL_WORD_FIRST_EN
                r_addr      <= {bus.Address[31:2], 2'b00};
                r_start_idx <= bus.Address[4:2];
`else
                r_addr      <= {bus.Address[31:5], 5'b00000};
`endif
                r_data <= '0;
                r_err  <= 1'b0;
                r_cnt  <= 3'd0;
            end else if (w_consume) begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (w_write) r_data[{w_idx, 5'b00000} +: 32] <= bus.AXIRData;

            if (w_write && w_final) begin
                r_done <= 1'b1;
                r_err  <= w_err;
            end else if (r_state == S_DONE && !bus.Enable) begin
                r_done <= 1'b0;
            end

            // Critical word: only the first stored beat of a live transfer.
            r_critv <= w_write && (r_cnt == 3'd0);
            if (w_write && (r_cnt == 3'd0)) r_crit <= bus.AXIRData;
        end
    end

    assign bus.AXIAddr      = r_addr;
    assign bus.AXIStartRead = r_start;
    assign bus.LR_Data      = r_data;
    assign bus.LR_Completed = r_done;
    assign bus.LR_Error     = r_err;
`ifdef CRITICAL_WORD_FIRST_EN
    assign bus.CritWord     = r_crit;
    assign bus.CritValid    = r_critv;
`else
    logic w_unused_crit;
    assign w_unused_crit    = ^{r_crit, r_critv};
    assign bus.CritWord     = 32'd0;
    assign bus.CritValid    = 1'b0;
`endif

endmodule
